// File: rtl/pll_pkg.sv
// Shared types and default constants for the PLL lock detector and its PLL top.
package pll_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRING,
    LOCKED
  } lock_state_t;

  localparam int DEF_WINDOW       = 64;
  localparam int DEF_TOL          = 1;
  localparam int DEF_LOCK_WINDOWS = 4;
  localparam int DEF_TIMEOUT      = 1024;
  localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/pll_lock_detector_if.sv
// Monitored clocks in, per-window lock status out.
interface pll_lock_detector_if
  import pll_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             ref_in;
  logic             fb_in;
  logic             locked;
  logic             win_done;
  logic [CNT_W-1:0] fb_count;
  logic             too_fast;
  logic             too_slow;

  // Clock source / status consumer side
  modport master (
    output ref_in, fb_in,
    input  locked, win_done, fb_count, too_fast, too_slow
  );

  // Lock detector side
  modport slave (
    input  ref_in, fb_in,
    output locked, win_done, fb_count, too_fast, too_slow
  );

endinterface

// File: rtl/pll_lock_detector_edge_sync.sv
// Two-flop synchronizer followed by a single-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, prev;

  // Synchronize the asynchronous input and keep one cycle of history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;

endmodule

// File: rtl/pll_lock_detector.sv
// Counts feedback edges per window of reference edges and tracks PLL lock.
module pll_lock_detector
  import pll_pkg::*;
#(
  parameter int WINDOW       = DEF_WINDOW,
  parameter int TOL          = DEF_TOL,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                clk,
  input logic                rst,
  pll_lock_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_REF  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(WINDOW - TOL);
  localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(WINDOW + TOL);
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_TRIP = CNT_W'(TIMEOUT - 1);
  localparam int               GW        = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GW-1:0]    GOOD_TGT  = GW'(LOCK_WINDOWS);

  logic             ref_edge, fb_edge;
  logic [CNT_W-1:0] ref_cnt, fb_cnt, idle_cnt, fb_cap;
  logic             win_close, timed_out, good;
  lock_state_t      state_q, state_d;
  logic [GW-1:0]    good_q, good_d;
  logic             locked_q, win_done_q, too_fast_q, too_slow_q;
  logic [CNT_W-1:0] fb_count_q;

  edge_sync u_ref_sync (.clk(clk), .rst(rst), .din(bus.ref_in), .pulse(ref_edge));
  edge_sync u_fb_sync  (.clk(clk), .rst(rst), .din(bus.fb_in),  .pulse(fb_edge));

  // Window close / timeout detection; the captured count includes a coincident fb edge.
  always_comb begin
    win_close = ref_edge && (ref_cnt == LAST_REF);
    timed_out = !ref_edge && (idle_cnt >= IDLE_TRIP);
    fb_cap    = fb_cnt;
    if (fb_edge && (fb_cnt != '1)) fb_cap = fb_cnt + 1'b1;
    good      = (fb_cap >= LO_LIM) && (fb_cap <= HI_LIM);
  end

  // Reference, feedback and idle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt  <= '0;
      fb_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      if (ref_edge) idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
      // Counts stay cleared while the reference is missing, so a fresh window starts with it.
      if (win_close || timed_out) begin
        ref_cnt <= '0;
        fb_cnt  <= '0;
      end else begin
        if (ref_edge) ref_cnt <= ref_cnt + 1'b1;
        fb_cnt <= fb_cap;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNLOCKED;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock next-state: evaluated at window close, forced down on reference timeout.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (timed_out) begin
      state_d = UNLOCKED;
      good_d  = '0;
    end else if (win_close) begin
      if (!good) begin
        state_d = UNLOCKED;
        good_d  = '0;
      end else begin
        case (state_q)
          UNLOCKED: begin
            good_d  = GW'(1);
            state_d = (GOOD_TGT == GW'(1)) ? LOCKED : ACQUIRING;
          end
          ACQUIRING: begin
            good_d = good_q + 1'b1;
            if (good_d == GOOD_TGT) state_d = LOCKED;
          end
          LOCKED:  state_d = LOCKED;
          default: begin
            state_d = UNLOCKED;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  // Registered window results, all updating together with win_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_done_q <= 1'b0;
      locked_q   <= 1'b0;
      fb_count_q <= '0;
      too_fast_q <= 1'b0;
      too_slow_q <= 1'b0;
    end else begin
      win_done_q <= win_close;
      locked_q   <= (state_d == LOCKED);
      if (win_close) begin
        fb_count_q <= fb_cap;
        too_fast_q <= (fb_cap > HI_LIM);
        too_slow_q <= (fb_cap < LO_LIM);
      end
    end
  end

  assign bus.locked   = locked_q;
  assign bus.win_done = win_done_q;
  assign bus.fb_count = fb_count_q;
  assign bus.too_fast = too_fast_q;
  assign bus.too_slow = too_slow_q;

endmodule

// File: tb/tb_pll_lock_detector.sv
// Self-checking bench: table of per-window feedback edge counts with expected results.
module tb_pll_lock_detector;
  import pll_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pll_lock_detector_if #(.CNT_W(16)) bus4 ();
  pll_lock_detector_if #(.CNT_W(16)) bus1 ();

  pll_lock_detector dut (.clk(clk), .rst(rst), .bus(bus4));
  pll_lock_detector #(.LOCK_WINDOWS(1)) dut_l1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int fb_edges;
    bit fast;
    bit slow;
    bit lock4;
    bit lock1;
  } vec_t;

  typedef struct {
    logic [15:0] count;
    bit          fast;
    bit          slow;
    bit          lock4;
    bit          lock1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int n, input bit f, input bit s, input bit l4, input bit l1);
    vec_t v;
    v.fb_edges = n; v.fast = f; v.slow = s; v.lock4 = l4; v.lock1 = l1;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_inputs(input logic r, input logic f);
    if (r && !bus4.ref_in) last_rise = cyc;
    bus4.ref_in = r; bus1.ref_in = r;
    bus4.fb_in  = f; bus1.fb_in  = f;
  endtask

  // Ref: period 40, rising at t%40==0. Fb: n rising edges spread over t=0..2520.
  task automatic drive(input int t, input int n);
    int   p;
    logic r, f;
    p = (n <= 1) ? 2520 : 2520 / (n - 1);
    r = ((t % 40) < 20);
    f = (n > 0) && ((t % p) < 16) && ((t / p) < n);
    set_inputs(r, f);
  endtask

  task automatic observe();
    exp_t e;
    if (bus4.win_done) begin
      seen++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL win_done_unexpected: got pulse, want none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("fb_count", bus4.fb_count, e.count);
        check("too_fast", bus4.too_fast, e.fast);
        check("too_slow", bus4.too_slow, e.slow);
        check("locked",   bus4.locked,   e.lock4);
        check("l1_win_done", bus1.win_done, 1);
        check("l1_fb_count", bus1.fb_count, e.count);
        check("l1_locked",   bus1.locked,   e.lock1);
      end
    end else if (bus1.win_done) begin
      checks++; errors++;
      $display("FAIL l1_win_done_alone: got pulse, want none (cycle %0d)", cyc);
    end
  endtask

  task automatic run_window(input vec_t v);
    exp_t e;
    e.count = 16'(v.fb_edges); e.fast = v.fast; e.slow = v.slow;
    e.lock4 = v.lock4; e.lock1 = v.lock1;
    sb.push_back(e);
    seen = 0;
    for (int t = 0; t < 2560; t++) begin
      tick();
      observe();
      drive(t, v.fb_edges);
    end
    check("win_done_per_window", seen, 1);
  endtask

  task automatic timeout_phase();
    int fall;
    int pulses;
    fall = -1;
    pulses = 0;
    for (int k = 0; k < 1200; k++) begin
      tick();
      if (bus4.win_done || bus1.win_done) pulses++;
      if (fall < 0 && !bus4.locked) fall = cyc - last_rise;
      set_inputs(1'b0, ((k % 40) < 16));
    end
    check("timeout_no_win_done", pulses, 0);
    check("timeout_locked", bus4.locked, 0);
    check("timeout_l1_locked", bus1.locked, 0);
    check("timeout_fb_count_hold", bus4.fb_count, 63);
    check("timeout_too_slow_hold", bus4.too_slow, 0);
    checks++;
    if (fall < 1024 || fall > 1030) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles after last ref edge, want 1024..1030", fall);
    end
  endtask

  initial begin
    vec_t v;
    //   fb  fast slow L4 L1
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 1, 1);
    add(32, 0, 1, 0, 0);
    add(66, 1, 0, 0, 0);
    add(66, 1, 0, 0, 0);
    add(65, 0, 0, 0, 1);
    add(65, 0, 0, 0, 1);
    add(65, 0, 0, 0, 1);
    add(65, 0, 0, 1, 1);
    add(0,  0, 1, 0, 0);
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 0, 1);
    add(62, 0, 1, 0, 0);
    add(63, 0, 0, 0, 1);
    add(63, 0, 0, 0, 1);
    add(63, 0, 0, 0, 1);
    add(63, 0, 0, 1, 1);
    // after the reference timeout: fresh windows and relock
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 0, 1);
    add(64, 0, 0, 1, 1);

    rst = 1'b1;
    set_inputs(1'b0, 1'b0);
    repeat (4) tick();
    check("reset_locked",   bus4.locked,   0);
    check("reset_win_done", bus4.win_done, 0);
    check("reset_fb_count", bus4.fb_count, 0);
    check("reset_too_fast", bus4.too_fast, 0);
    check("reset_too_slow", bus4.too_slow, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 19) timeout_phase();
      run_window(tbl[i]);
    end

    // Partial window while locked, then asynchronous reset.
    for (int t = 0; t < 1000; t++) begin
      tick();
      observe();
      drive(t, 64);
    end
    #3;
    rst = 1'b1;
    set_inputs(1'b0, 1'b0);
    #1;
    check("arst_locked",    bus4.locked,   0);
    check("arst_win_done",  bus4.win_done, 0);
    check("arst_fb_count",  bus4.fb_count, 0);
    check("arst_too_fast",  bus4.too_fast, 0);
    check("arst_too_slow",  bus4.too_slow, 0);
    check("arst_l1_locked", bus1.locked,   0);
    repeat (3) tick();
    rst = 1'b0;

    v.fb_edges = 64; v.fast = 0; v.slow = 0; v.lock4 = 0; v.lock1 = 1;
    run_window(v);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
